// File: rtl/is_modn_stream.sv
// Streaming divisibility checker: folds a serial bit stream into its residue
// modulo MOD, one beat per accepted in_valid, in either MSB-first or LSB-first
// order. Per-frame results are captured on the last beat.
module is_modn_stream #(
    parameter int MOD = 3,
    parameter int RW  = (MOD > 2) ? $clog2(MOD) : 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    input  logic          in_last,
    input  logic          lsb_first,
    output logic [RW-1:0] residue,
    output logic          div,
    output logic          done,
    output logic [RW-1:0] frame_residue,
    output logic          frame_div,
    output logic [CW-1:0] frame_len
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [RW:0] MOD_V = (RW+1)'(MOD);

    state_t        state, state_nxt;
    logic [RW-1:0] weight;
    logic [CW-1:0] count;
    logic          mode;

    logic          first;
    logic          cur_mode;
    logic [RW-1:0] r_in, w_in, r_new, w_new;
    logic [CW-1:0] cnt_in, cnt_new;
    logic [RW:0]   sum_msb, sum_lsb, sum_sel;

    // Operands are at most 2*MOD-1, so one conditional subtract fully reduces.
    function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
        logic [RW:0] t;
        t = (x >= MOD_V) ? (x - MOD_V) : x;
        return t[RW-1:0];
    endfunction

    // Next residue/weight/count for the beat on the inputs; the first beat of
    // a frame starts from residue 0, weight 1, count 0 and uses the live mode.
    always_comb begin
        first    = (state == IDLE);
        cur_mode = first ? lsb_first : mode;
        r_in     = first ? '0 : residue;
        w_in     = first ? RW'(1) : weight;
        cnt_in   = first ? '0 : count;
        sum_msb  = {r_in, 1'b0} | {{RW{1'b0}}, in_bit};
        sum_lsb  = {1'b0, r_in} + (in_bit ? {1'b0, w_in} : '0);
        sum_sel  = cur_mode ? sum_lsb : sum_msb;
        r_new    = reduce(sum_sel);
        w_new    = reduce({w_in, 1'b0});
        cnt_new  = (cnt_in == {CW{1'b1}}) ? cnt_in : cnt_in + CW'(1);
    end

    // Frame FSM: a beat opens a frame, a last beat closes it.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            state_nxt = in_last ? IDLE : ACTIVE;
        end
    end

    // State and datapath registers; a gap (in_valid low) holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            residue       <= '0;
            weight        <= RW'(1);
            count         <= '0;
            mode          <= 1'b0;
            done          <= 1'b0;
            frame_residue <= '0;
            frame_div     <= 1'b0;
            frame_len     <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (in_valid) begin
                residue <= r_new;
                weight  <= w_new;
                count   <= cnt_new;
                if (first) begin
                    mode <= lsb_first;
                end
                if (in_last) begin
                    done          <= 1'b1;
                    frame_residue <= r_new;
                    frame_div     <= (r_new == '0);
                    frame_len     <= cnt_new;
                end
            end
        end
    end

    assign div = (residue == '0) && !rst;

endmodule

// File: tb/tb_is_modn_stream.sv
// Directed and randomized checks of is_modn_stream. Five instances with
// different MOD/CW share one input stream; each step checks the relevant one.
module tb_is_modn_stream;

    logic clk = 1'b0;
    logic rst, in_valid, in_bit, in_last, lsb_first;

    always #5 clk = ~clk;

    logic [0:0] r2, fr2;  logic d2, dn2, fd2; logic [2:0] fl2;
    logic [1:0] r3, fr3;  logic d3, dn3, fd3; logic [7:0] fl3;
    logic [2:0] r5, fr5;  logic d5, dn5, fd5; logic [7:0] fl5;
    logic [2:0] r7, fr7;  logic d7, dn7, fd7; logic [7:0] fl7;
    logic [7:0] r255, fr255; logic d255, dn255, fd255; logic [7:0] fl255;

    is_modn_stream #(.MOD(2), .CW(3)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .in_last(in_last), .lsb_first(lsb_first), .residue(r2), .div(d2),
        .done(dn2), .frame_residue(fr2), .frame_div(fd2), .frame_len(fl2));
    is_modn_stream #(.MOD(3)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .in_last(in_last), .lsb_first(lsb_first), .residue(r3), .div(d3),
        .done(dn3), .frame_residue(fr3), .frame_div(fd3), .frame_len(fl3));
    is_modn_stream #(.MOD(5)) u5 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .in_last(in_last), .lsb_first(lsb_first), .residue(r5), .div(d5),
        .done(dn5), .frame_residue(fr5), .frame_div(fd5), .frame_len(fl5));
    is_modn_stream #(.MOD(7)) u7 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .in_last(in_last), .lsb_first(lsb_first), .residue(r7), .div(d7),
        .done(dn7), .frame_residue(fr7), .frame_div(fd7), .frame_len(fl7));
    is_modn_stream #(.MOD(255)) u255 (.clk(clk), .rst(rst), .in_valid(in_valid),
        .in_bit(in_bit), .in_last(in_last), .lsb_first(lsb_first), .residue(r255), .div(d255),
        .done(dn255), .frame_residue(fr255), .frame_div(fd255), .frame_len(fl255));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat; outputs are sampled 1 time unit after the edge.
    task automatic beat(input logic b, input logic last, input logic lsb);
        in_valid  = 1'b1;
        in_bit    = b;
        in_last   = last;
        lsb_first = lsb;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            in_bit = ~in_bit;
            in_last = 1'b1;
            tick();
            in_last = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] bits3 [8];
        logic [1:0] res3 [8];
        logic [9:0] bits2;
        logic [1:0] r2_hold;
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; lsb_first = 1'b0;
        tick(); tick();

        // Reset state, beat during reset discarded, div forced low.
        chk("rst_residue", 32'(r3), 0);
        chk("rst_div", 32'(d3), 0);
        chk("rst_done", 32'(dn3), 0);
        chk("rst_frame_residue", 32'(fr3), 0);
        chk("rst_frame_div", 32'(fd3), 0);
        chk("rst_frame_len", 32'(fl3), 0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("div_after_rst", 32'(d3), 1);

        // Divisor 3, MSB-first 10100010.
        bits3 = '{1, 0, 1, 0, 0, 0, 1, 0};
        res3  = '{1, 2, 2, 1, 2, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            beat(bits3[i][0], i == 7, 1'b0);
            chk($sformatf("m3_residue_%0d", i), 32'(r3), 32'(res3[i]));
            chk($sformatf("m3_done_%0d", i), 32'(dn3), (i == 7) ? 1 : 0);
        end
        chk("m3_frame_residue", 32'(fr3), 0);
        chk("m3_frame_div", 32'(fd3), 1);
        chk("m3_frame_len", 32'(fl3), 8);
        tick();
        chk("m3_done_once", 32'(dn3), 0);
        chk("m3_residue_hold", 32'(r3), 0);
        chk("m3_div_hold", 32'(d3), 1);

        // Divisor 5, bits 1101: MSB-first (13), lsb_first flips after beat 1.
        beat(1, 0, 0); beat(1, 0, 1); beat(0, 0, 1); beat(1, 1, 1);
        chk("m5_msb_residue", 32'(r5), 3);
        chk("m5_msb_frame_residue", 32'(fr5), 3);
        chk("m5_msb_frame_div", 32'(fd5), 0);
        chk("m5_msb_done", 32'(dn5), 1);
        tick();
        // LSB-first (11), lsb_first drops after beat 1.
        beat(1, 0, 1); beat(1, 0, 0); beat(0, 0, 0); beat(1, 1, 0);
        chk("m5_lsb_frame_residue", 32'(fr5), 1);
        chk("m5_lsb_frame_div", 32'(fd5), 0);
        chk("m5_lsb_frame_len", 32'(fl5), 4);
        tick();

        // Divisor 7, back-to-back frames 111 and 1110; divisor 5 shows the restart at 0.
        beat(1, 0, 0); beat(1, 0, 0); beat(1, 1, 0);
        chk("m7_f1_done", 32'(dn7), 1);
        chk("m7_f1_frame_residue", 32'(fr7), 0);
        chk("m7_f1_frame_len", 32'(fl7), 3);
        chk("m5_f1_frame_residue", 32'(fr5), 2);
        beat(1, 0, 0);
        chk("m7_f2_first_done", 32'(dn7), 0);
        chk("m5_f2_first_residue", 32'(r5), 1);
        beat(1, 0, 0); beat(1, 0, 0); beat(0, 1, 0);
        chk("m7_f2_done", 32'(dn7), 1);
        chk("m7_f2_frame_residue", 32'(fr7), 0);
        chk("m7_f2_frame_div", 32'(fd7), 1);
        chk("m7_f2_frame_len", 32'(fl7), 4);
        tick();

        // Divisor 3, reset mid-frame abandons it.
        beat(1, 0, 0); chk("m3r_done_0", 32'(dn3), 0);
        beat(0, 0, 0); chk("m3r_done_1", 32'(dn3), 0);
        beat(1, 0, 0); chk("m3r_done_2", 32'(dn3), 0);
        chk("m3r_residue_pre", 32'(r3), 2);
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
        #1;
        chk("m3r_div_during_rst_a", 32'(d3), 0);
        tick();
        chk("m3r_div_during_rst_b", 32'(d3), 0);
        chk("m3r_residue_rst", 32'(r3), 0);
        chk("m3r_done_rst", 32'(dn3), 0);
        chk("m3r_frame_len_rst", 32'(fl3), 0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        beat(1, 0, 0);
        chk("m3r_post_residue", 32'(r3), 1);
        beat(1, 1, 0);
        chk("m3r_post_done", 32'(dn3), 1);
        chk("m3r_post_frame_residue", 32'(fr3), 0);
        chk("m3r_post_frame_div", 32'(fd3), 1);
        chk("m3r_post_frame_len", 32'(fl3), 2);
        tick();

        // Divisor 2, CW=3: 10-beat frame with gaps saturates the length at 7.
        bits2 = 10'b1011001011;
        for (int i = 0; i < 10; i++) begin
            beat(bits2[9-i], i == 9, 1'b0);
            if (i < 9) begin
                r2_hold = 2'(r2);
                gap(i % 3);
                chk($sformatf("m2_gap_hold_%0d", i), 32'(r2), 32'(r2_hold));
                chk($sformatf("m2_residue_%0d", i), 32'(r2), 32'(bits2[9-i]));
            end
        end
        chk("m2_residue_last", 32'(r2), 1);
        chk("m2_done", 32'(dn2), 1);
        chk("m2_frame_residue", 32'(fr2), 1);
        chk("m2_frame_div", 32'(fd2), 0);
        chk("m2_frame_len_sat", 32'(fl2), 7);
        tick();

        // Random frames, both orders, random gaps and mid-frame lsb_first noise.
        for (int f = 0; f < 24; f++) begin
            int len;
            logic md;
            longint val;
            len = $urandom_range(1, 12);
            md  = 1'($urandom_range(0, 1));
            val = 0;
            for (int i = 0; i < len; i++) begin
                logic b;
                b = 1'($urandom_range(0, 1));
                if (md) val = val + (longint'(b) << i);
                else    val = val * 2 + longint'(b);
                gap($urandom_range(0, 2));
                beat(b, i == len - 1, (i == 0) ? md : 1'($urandom_range(0, 1)));
            end
            chk($sformatf("rnd%0d_done", f), 32'(dn3), 1);
            chk($sformatf("rnd%0d_m2_res", f), 32'(fr2), 32'(val % 2));
            chk($sformatf("rnd%0d_m2_div", f), 32'(fd2), 32'(val % 2 == 0));
            chk($sformatf("rnd%0d_m2_len", f), 32'(fl2), (len > 7) ? 7 : len);
            chk($sformatf("rnd%0d_m3_res", f), 32'(fr3), 32'(val % 3));
            chk($sformatf("rnd%0d_m3_div", f), 32'(fd3), 32'(val % 3 == 0));
            chk($sformatf("rnd%0d_m3_len", f), 32'(fl3), len);
            chk($sformatf("rnd%0d_m7_res", f), 32'(fr7), 32'(val % 7));
            chk($sformatf("rnd%0d_m7_div", f), 32'(fd7), 32'(val % 7 == 0));
            chk($sformatf("rnd%0d_m255_res", f), 32'(fr255), 32'(val % 255));
            chk($sformatf("rnd%0d_m255_div", f), 32'(fd255), 32'(val % 255 == 0));
            chk($sformatf("rnd%0d_m255_len", f), 32'(fl255), len);
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
